buffered_seq_alu: RTL and testbench

BUFFERED_SEQ_ALU -- requirements
Module: buffered_seq_alu

---
 rtl/buffered_seq_alu.sv | 213 +++++++++++++++++++++
 tb/tb_buffered_seq_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_seq_alu.sv
// Command-FIFO-fed sequential ALU: ADD/SUB complete in one EXEC cycle, MUL (shift-add)
// and DIV (restoring, on magnitudes) take WIDTH cycles; each result is held until accepted.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the FIFO head when count > 0
// EXEC   | iterating; cycle down-counter reaches zero on the last step
// RESULT | result registered on outputs, held until out_ready
module buffered_seq_alu #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   opcode,
  input  logic                         in_signed,
  input  logic [WIDTH-1:0]             in1,
  input  logic [WIDTH-1:0]             in2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_high,
  output logic [WIDTH-1:0]             out_low,
  output logic                         flag,
  output logic [1:0]                   out_opcode,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  cmd_t             fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  cmd_t             head;
  logic             push, pop;

  state_t           state;
  logic [NW-1:0]    cnt;
  logic [1:0]       op_r;
  logic             sgn_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] hi_r, lo_r, mag_b;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign head     = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && push)
      fifo_mem[wr_ptr] <= {opcode, in_signed, in1, in2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // One iteration step: MUL keeps {hi,lo} as accumulator/multiplier, DIV as remainder/quotient.
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff, hi_n, lo_n;
  logic               div_ge, neg_q;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_flag;

  assign mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_b} : '0);
  assign div_sh   = {hi_r, lo_r[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, mag_b};
  assign div_diff = div_sh[WIDTH-1:0] - mag_b;
  assign neg_q    = sgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
  assign sum      = {1'b0, a_r} + {1'b0, b_r};
  assign diff     = a_r - b_r;

  always_comb begin
    hi_n     = '0;
    lo_n     = '0;
    prod_f   = '0;
    res_hi   = '0;
    res_lo   = '0;
    res_flag = 1'b0;
    if (op_r == OP_MUL) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_r[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_n = {lo_r[WIDTH-2:0], div_ge};
    end
    prod_f = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    case (op_r)
      OP_ADD: begin
        res_lo   = sum[WIDTH-1:0];
        res_flag = sgn_r ? ((a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]))
                         : sum[WIDTH];
      end
      OP_SUB: begin
        res_lo   = diff;
        res_flag = sgn_r ? ((a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]))
                         : (a_r < b_r);
      end
      OP_MUL: begin
        {res_hi, res_lo} = prod_f;
        res_flag = sgn_r ? (prod_f[2*WIDTH-1:WIDTH] != {WIDTH{prod_f[WIDTH-1]}})
                         : (prod_f[2*WIDTH-1:WIDTH] != '0);
      end
      default: begin
        if (b_r == '0) begin
          res_lo   = '1;
          res_hi   = a_r;
          res_flag = 1'b1;
        end else if (sgn_r && (a_r == MIN_VAL) && (b_r == '1)) begin
          res_lo   = MIN_VAL;
          res_flag = 1'b1;
        end else begin
          res_lo = neg_q ? -lo_n : lo_n;
          res_hi = (sgn_r && a_r[WIDTH-1]) ? -hi_n : hi_n;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_high   <= '0;
      out_low    <= '0;
      flag       <= 1'b0;
      out_opcode <= '0;
      cnt        <= '0;
      op_r       <= '0;
      sgn_r      <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      mag_b      <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          op_r  <= head.op;
          sgn_r <= head.sgn;
          a_r   <= head.a;
          b_r   <= head.b;
          hi_r  <= '0;
          lo_r  <= (head.op == OP_MUL) ? mag(head.b, head.sgn) : mag(head.a, head.sgn);
          mag_b <= (head.op == OP_MUL) ? mag(head.a, head.sgn) : mag(head.b, head.sgn);
          cnt   <= head.op[1] ? NW'(WIDTH - 1) : '0;
          state <= EXEC;
          busy  <= 1'b1;
        end
        EXEC: begin
          hi_r <= hi_n;
          lo_r <= lo_n;
          if (cnt == '0) begin
            state      <= RESULT;
            out_valid  <= 1'b1;
            out_high   <= res_hi;
            out_low    <= res_lo;
            flag       <= res_flag;
            out_opcode <= op_r;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESULT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffered_seq_alu.sv
// Bench for buffered_seq_alu (WIDTH=4, DEPTH=4): directed scenarios plus random commands
// checked against an integer-arithmetic reference model.
module tb_buffered_seq_alu;

  logic       clk, reset, in_valid, in_ready, in_signed, out_valid, out_ready, flag, busy;
  logic [1:0] opcode, out_opcode;
  logic [3:0] in1, in2, out_high, out_low;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] op;
    logic       fl;
    logic [3:0] hi;
    logic [3:0] lo;
  } res_t;

  res_t expq[$];

  buffered_seq_alu #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_signed(in_signed), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out_high(out_high), .out_low(out_low),
    .flag(flag), .out_opcode(out_opcode), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [1:0] op, input logic sg,
                                 input logic [3:0] a, input logic [3:0] b);
    res_t x;
    int sa, sb, r, q, rm;
    sa = sg ? int'($signed(a)) : int'(a);
    sb = sg ? int'($signed(b)) : int'(b);
    x = '0;
    x.op = op;
    case (op)
      2'd0: begin r = sa + sb; x.lo = r[3:0]; x.fl = sg ? (r > 7 || r < -8) : (r > 15); end
      2'd1: begin r = sa - sb; x.lo = r[3:0]; x.fl = sg ? (r > 7 || r < -8) : (r < 0); end
      2'd2: begin
        r = sa * sb; x.hi = r[7:4]; x.lo = r[3:0];
        x.fl = sg ? (r > 7 || r < -8) : (r > 15);
      end
      default: begin
        if (sb == 0) begin
          x.lo = 4'hF; x.hi = a; x.fl = 1'b1;
        end else if (sg && sa == -8 && sb == -1) begin
          x.lo = 4'h8; x.hi = 4'h0; x.fl = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb;
          x.lo = q[3:0]; x.hi = rm[3:0];
        end
      end
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, "_low"},  32'(out_low),    32'(e.lo));
    chk({tag, "_high"}, 32'(out_high),   32'(e.hi));
    chk({tag, "_flag"}, 32'(flag),       32'(e.fl));
    chk({tag, "_op"},   32'(out_opcode), 32'(e.op));
  endtask

  // Single command from an idle engine with out_ready held high.
  task automatic do_cmd(input logic [1:0] op, input logic sg, input logic [3:0] a, input logic [3:0] b);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = op; in_signed = sg; in1 = a; in2 = b;
    step();
    in_valid = 1'b0;
    step();
    chk("busy_after_pop", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), op[1] ? 32'd4 : 32'd1);
    check_res("cmd", model(op, sg, a, b));
    step();
    chk("valid_fall", 32'(out_valid), 32'd0);
  endtask

  task automatic collect(input int n);
    int got, cyc;
    res_t e;
    got = 0; cyc = 0;
    while (got < n && cyc < 300) begin
      if (out_valid) begin
        if (expq.size() > 0) e = expq.pop_front();
        else e = '0;
        check_res("drain", e);
        got++;
      end
      step();
      cyc++;
    end
    chk("drain_count", 32'(got), 32'(n));
  endtask

  initial begin
    int acc;
    logic [1:0] rop;
    logic       rsg;
    logic [3:0] ra, rb;
    res_t       e;

    reset = 1'b1; in_valid = 1'b0; opcode = 2'd0; in_signed = 1'b0;
    in1 = 4'd0; in2 = 4'd0; out_ready = 1'b1;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_high", 32'(out_high), 32'd0);
    chk("rst_low", 32'(out_low), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_op", 32'(out_opcode), 32'd0);
    reset = 1'b0;
    step();

    do_cmd(2'd0, 1'b0, 4'h9, 4'h8);
    do_cmd(2'd0, 1'b1, 4'h7, 4'h1);
    do_cmd(2'd2, 1'b0, 4'hF, 4'hF);
    do_cmd(2'd2, 1'b1, 4'hD, 4'h5);
    do_cmd(2'd2, 1'b1, 4'h2, 4'hD);
    do_cmd(2'd3, 1'b0, 4'h7, 4'h0);
    do_cmd(2'd3, 1'b1, 4'h9, 4'h2);
    do_cmd(2'd3, 1'b1, 4'h8, 4'hF);

    // Mixed signedness queued back to back.
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 2'd1; in_signed = 1'b0; in1 = 4'h2; in2 = 4'h5;
    expq.push_back(model(2'd1, 1'b0, 4'h2, 4'h5));
    step();
    in_signed = 1'b1;
    expq.push_back(model(2'd1, 1'b1, 4'h2, 4'h5));
    step();
    in_valid = 1'b0;
    collect(2);

    // Backpressure: six back-to-back offers while the consumer stalls.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3)); rsg = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      in_valid = 1'b1; opcode = rop; in_signed = rsg; in1 = ra; in2 = rb;
      if (in_ready) acc++;
      if (i < 5) expq.push_back(model(rop, rsg, ra, rb));
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(count), 32'd4);
    repeat (6) step();
    e = expq[0];
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_hold_count", 32'(count), 32'd4);
      check_res("bp_hold", e);
      step();
    end
    out_ready = 1'b1;
    collect(5);
    chk("bp_end_count", 32'(count), 32'd0);
    chk("bp_end_busy", 32'(busy), 32'd0);

    // Reset during the second EXEC cycle of a MUL with two commands queued.
    in_valid = 1'b1; opcode = 2'd2; in_signed = 1'b0; in1 = 4'h6; in2 = 4'h7;
    step();
    opcode = 2'd0; in1 = 4'h1; in2 = 4'h1;
    step();
    opcode = 2'd1;
    step();
    chk("mr_pre_count", 32'(count), 32'd2);
    chk("mr_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mr_no_result", 32'(out_valid), 32'd0);
      step();
    end
    do_cmd(2'd0, 1'b0, 4'h3, 4'h4);

    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
